// File: rtl/mem_ctrl.sv
// mem_ctrl: serves 1..4 byte memctl LOAD/STORE requests as byte cycles on an 8-bit synchronous RAM.
// Define MEMCTL_LAST_HIT_EN to add a one-word buffer that answers repeated word loads without RAM cycles.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [1:0]        memctl_op,
    input  logic [1:0]        memctl_len,
    input  logic [ADDR_W-1:0] memctl_addr,
    input  logic [31:0]       memctl_in,
    output logic              memctl_rdy,
    output logic [31:0]       memctl_out,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    state_t state, state_nx;
    logic [1:0] len, c;
    logic [2:0] i;
    logic [ADDR_W-1:0] base;
    logic [31:0] data, cap_word, hit_d;
    logic issued, is_ld, is_st, accept, last_cap, last_wr, hit;

    assign is_ld = memctl_op == 2'b01;
    assign is_st = memctl_op == 2'b10;
    assign accept = state == IDLE && rdy_in && (is_ld || is_st);
    assign last_cap = state == RD && rdy_in && issued && c == len;
    assign last_wr = state == WR && rdy_in && i == {1'b0, len} + 3'd1;
    // byte c of the result is still zero, so OR merges the incoming byte
    assign cap_word = memctl_out | (32'(mem_din) << {c, 3'b000});
    assign mem_a = base + ADDR_W'(i);
    assign mem_dout = 8'(data >> {i, 3'b000});

`ifdef MEMCTL_LAST_HIT_EN
    logic hit_v;
    logic [ADDR_W-1:0] hit_a;
    assign hit = is_ld && memctl_len == 2'b11 && hit_v && hit_a == memctl_addr;
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_v <= 1'b0;
            hit_a <= '0;
            hit_d <= '0;
        end else if (accept && is_st) begin
            hit_v <= 1'b0;
        end else if (last_cap && len == 2'b11) begin
            hit_v <= 1'b1;
            hit_a <= base;
            hit_d <= cap_word;
        end
    end
`else
    assign hit = 1'b0;
    assign hit_d = '0;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        memctl_rdy = state == DONE && rdy_in;
        mem_wr = state == WR && rdy_in && !last_wr;
        case (state)
            IDLE: state_nx = !accept ? IDLE : hit ? DONE : is_ld ? RD : WR;
            RD: state_nx = last_cap ? DONE : RD;
            WR: state_nx = last_wr ? DONE : WR;
            DONE: state_nx = rdy_in ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            len <= '0;
            base <= '0;
            data <= '0;
            i <= '0;
            c <= '0;
            issued <= 1'b0;
            memctl_out <= '0;
        end else if (!rdy_in) begin
            // a paused issue is lost, so re-issue from the next byte to capture
            if (state == RD) begin
                i <= {1'b0, c};
                issued <= 1'b0;
            end
        end else if (accept) begin
            len <= memctl_len;
            base <= memctl_addr;
            data <= memctl_in;
            i <= '0;
            c <= '0;
            issued <= 1'b0;
            memctl_out <= hit ? hit_d : '0;
        end else if (state == RD) begin
            issued <= 1'b1;
            i <= i == {1'b0, len} ? i : i + 3'd1;
            if (issued) begin
                memctl_out <= cap_word;
                c <= c + 2'd1;
            end
        end else if (state == WR) begin
            i <= i + 3'd1;
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: random and directed memctl traffic checked against a byte-array memory model.
module tb_mem_ctrl;
    logic clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1;
    logic [1:0] memctl_op = 2'b00, memctl_len = 2'b00;
    logic [31:0] memctl_addr = '0, memctl_in = '0;
    logic memctl_rdy, mem_wr;
    logic [31:0] memctl_out, mem_a;
    logic [7:0] mem_din = '0, mem_dout;
    int total = 0, bad = 0, rdy_cnt = 0;
    logic [7:0] ram[logic [31:0]];
    logic [7:0] mdl[logic [31:0]];
    logic [39:0] wq[$];
    logic lh_v = 1'b0;
    logic [31:0] lh_a = '0;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .memctl_op(memctl_op), .memctl_len(memctl_len), .memctl_addr(memctl_addr),
        .memctl_in(memctl_in), .memctl_rdy(memctl_rdy), .memctl_out(memctl_out),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction
    function automatic logic [7:0] mdl_rd(input logic [31:0] a);
        return mdl.exists(a) ? mdl[a] : dflt(a);
    endfunction

    // synchronous RAM: read-before-write, data visible after the edge
    always @(posedge clk_in) begin
        mem_din <= ram_rd(mem_a);
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    always @(negedge clk_in) begin
        if (mem_wr) wq.push_back({mem_a, mem_dout});
        if (memctl_rdy) rdy_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic rst_vals();
        chk("rst_rdy", 64'(memctl_rdy), 0);
        chk("rst_out", 64'(memctl_out), 0);
        chk("rst_a", 64'(mem_a), 0);
        chk("rst_dout", 64'(mem_dout), 0);
        chk("rst_wr", 64'(mem_wr), 0);
    endtask

    // lat_req used only when pauses are requested; otherwise latency follows from N and the hit buffer
    task automatic txn(input logic [1:0] op, input logic [1:0] len, input logic [31:0] addr,
                       input logic [31:0] din, input logic [15:0] pmask, input int lat_req);
        int n, lat, rc0, lat_exp;
        logic [31:0] exp_out, got;
        logic hit;
        logic [39:0] exp_w[$];
        n = int'(len) + 1;
        exp_out = '0;
        hit = 1'b0;
        if (op == 2'b01) begin
            for (int k = 0; k < n; k++) exp_out[8*k +: 8] = mdl_rd(addr + 32'(k));
`ifdef MEMCTL_LAST_HIT_EN
            hit = lh_v && len == 2'b11 && lh_a == addr;
            if (len == 2'b11) begin
                lh_v = 1'b1;
                lh_a = addr;
            end
`endif
        end else begin
            for (int k = 0; k < n; k++) begin
                exp_w.push_back({addr + 32'(k), din[8*k +: 8]});
                mdl[addr + 32'(k)] = din[8*k +: 8];
            end
            lh_v = 1'b0;
        end
        lat_exp = pmask != 0 ? lat_req : hit ? 0 : n + 1;
        wq.delete();
        rc0 = rdy_cnt;
        lat = -1;
        got = '0;
        memctl_op = op;
        memctl_len = len;
        memctl_addr = addr;
        memctl_in = din;
        rdy_in = 1'b1;
        @(posedge clk_in);
        #1;
        memctl_op = 2'b00;
        memctl_len = 2'($urandom);
        memctl_addr = $urandom;
        memctl_in = $urandom;
        for (int k = 0; k < 64; k++) begin
            rdy_in = (k < 16 && pmask[k[3:0]]) ? 1'b0 : 1'b1;
            @(negedge clk_in);
            if (memctl_rdy) begin
                lat = k;
                got = memctl_out;
                break;
            end
            @(posedge clk_in);
            #1;
        end
        @(posedge clk_in);
        #1;
        rdy_in = 1'b1;
        @(negedge clk_in);
        #1;
        if (lat_exp >= 0) chk("latency", 64'(lat), 64'(lat_exp));
        else chk("complete", 64'(lat >= 0), 1);
        chk("pulse_cnt", 64'(rdy_cnt - rc0), 1);
        if (op == 2'b01) begin
            chk("ld_data", 64'(got), 64'(exp_out));
            chk("ld_hold", 64'(memctl_out), 64'(exp_out));
            chk("ld_nowr", 64'(wq.size()), 0);
        end else begin
            chk("wr_cnt", 64'(wq.size()), 64'(exp_w.size()));
            for (int k = 0; k < exp_w.size() && k < wq.size(); k++) chk("wr_byte", 64'(wq[k]), 64'(exp_w[k]));
        end
        for (int k = -1; k <= 4; k++) chk("ram", 64'(ram_rd(addr + 32'(k))), 64'(mdl_rd(addr + 32'(k))));
    endtask

    task automatic idle_check(input logic [1:0] op, input logic rdy);
        int rc0;
        rc0 = rdy_cnt;
        wq.delete();
        memctl_op = op;
        memctl_len = 2'b11;
        memctl_addr = 32'h1000;
        rdy_in = rdy;
        repeat (4) @(posedge clk_in);
        #1;
        memctl_op = 2'b00;
        rdy_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        chk("idle_rdy", 64'(rdy_cnt - rc0), 0);
        chk("idle_wr", 64'(wq.size()), 0);
    endtask

    initial begin
        int rc0;
        logic [1:0] op, len;
        logic [31:0] addr;
        logic [15:0] pm;
        repeat (2) @(posedge clk_in);
        #1;
        rst_vals();
        rst_in = 1'b0;
        ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h00; ram[32'h1002] = 8'h50; ram[32'h1003] = 8'h00;
        mdl[32'h1000] = 8'h13; mdl[32'h1001] = 8'h00; mdl[32'h1002] = 8'h50; mdl[32'h1003] = 8'h00;
        ram[32'h3] = 8'hF0;
        mdl[32'h3] = 8'hF0;
        txn(2'b01, 2'b11, 32'h1000, '0, '0, -1);
        chk("t1_word", 64'(memctl_out), 64'h00500013);
        txn(2'b10, 2'b01, 32'h2001, 32'hAABBCCDD, '0, -1);
        txn(2'b01, 2'b00, 32'h3, '0, '0, -1);
        chk("t3_zext", 64'(memctl_out), 64'h000000F0);
        txn(2'b01, 2'b11, 32'h1000, '0, 16'h0038, 9);
        chk("t4_word", 64'(memctl_out), 64'h00500013);
        txn(2'b01, 2'b11, 32'h1000, '0, '0, -1);
        txn(2'b10, 2'b00, 32'h1001, 32'h77, '0, -1);
        txn(2'b01, 2'b11, 32'h1000, '0, '0, -1);
        idle_check(2'b00, 1'b1);
        idle_check(2'b11, 1'b1);
        idle_check(2'b01, 1'b0);
        // reset in the middle of a word store after byte 0 has been written
        rc0 = rdy_cnt;
        wq.delete();
        memctl_op = 2'b10; memctl_len = 2'b11; memctl_addr = 32'h3000; memctl_in = 32'h11223344;
        @(posedge clk_in);
        #1;
        memctl_op = 2'b00;
        @(negedge clk_in);
        chk("t5_wr0", 64'(mem_wr), 1);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        #1;
        rst_vals();
        mdl[32'h3000] = 8'h44;
        lh_v = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        repeat (6) @(posedge clk_in);
        #1;
        chk("t5_norpy", 64'(rdy_cnt - rc0), 0);
        chk("t5_wrs", 64'(wq.size()), 1);
        for (int k = 0; k < 4; k++) chk("t5_ram", 64'(ram_rd(32'h3000 + 32'(k))), 64'(mdl_rd(32'h3000 + 32'(k))));
        for (int t = 0; t < 60; t++) begin
            op = $urandom_range(0, 1) ? 2'b10 : 2'b01;
            len = 2'($urandom);
            addr = $urandom_range(0, 3) == 0 ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                             : 32'h1000 + 32'($urandom_range(0, 7));
            pm = $urandom_range(0, 2) == 0 ? 16'($urandom & $urandom) : 16'h0;
            txn(op, len, addr, $urandom, pm, -1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
